// File: rtl/reg_dump_tx.sv
// Register-bank dump transmitter: walks all 32 registers through a spare read port
// and sends each one over UART 8N1, most significant byte first, LSB first within a byte.
module reg_dump_tx #(
    parameter int N            = 32,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [4:0]   ra,
    input  logic [N-1:0] rd,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int NBYTES = N / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BDW    = $clog2(CLKS_PER_BIT);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [BDW-1:0] LAST_TICK = BDW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [4:0]     idx_reg, idx_next;
    logic [BCW-1:0] byte_cnt_reg, byte_cnt_next;
    logic [N-1:0]   word_reg, word_next;
    logic [7:0]     shift_reg, shift_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [BDW-1:0] baud_reg, baud_next;

    logic           baud_done;
    logic [N-1:0]   word_shifted;

    assign ra           = idx_reg;
    assign baud_done    = (baud_reg == LAST_TICK);
    assign word_shifted = word_reg << 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            baud_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            byte_cnt_reg <= byte_cnt_next;
            word_reg     <= word_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            baud_reg     <= baud_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        byte_cnt_next = byte_cnt_reg;
        word_next     = word_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        baud_next     = baud_reg;
        tx            = 1'b1;
        busy          = (state_reg != S_IDLE);
        done          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    state_next = S_LOAD;
                end
            end

            // The whole register is captured here; later bank writes cannot
            // disturb bytes of this register that are still to be sent.
            S_LOAD: begin
                word_next     = rd;
                shift_next    = rd[N-1 -: 8];
                byte_cnt_next = '0;
                baud_next     = '0;
                state_next    = S_START;
            end

            S_START: begin
                tx        = 1'b0;
                baud_next = baud_done ? '0 : baud_reg + 1'b1;
                if (baud_done) begin
                    bit_cnt_next = '0;
                    state_next   = S_DATA;
                end
            end

            S_DATA: begin
                tx        = shift_reg[0];
                baud_next = baud_done ? '0 : baud_reg + 1'b1;
                if (baud_done) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end

            S_STOP: begin
                tx        = 1'b1;
                baud_next = baud_done ? '0 : baud_reg + 1'b1;
                if (baud_done) begin
                    if (byte_cnt_reg < LAST_BYTE) begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                        word_next     = word_shifted;
                        shift_next    = word_shifted[N-1 -: 8];
                        state_next    = S_START;
                    end else if (idx_reg == 5'd31) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + 5'd1;
                        state_next = S_LOAD;
                    end
                end
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: a bank model feeds rd, a UART receiver decodes tx,
// and each step checks bytes, done timing and control outputs against hand-computed values.
module tb_reg_dump_tx;

    localparam int N        = 32;
    localparam int CPB      = 4;
    localparam int REG_CYC  = 1 + (N / 8) * 10 * CPB;   // 161
    localparam int DUMP_CYC = 32 * REG_CYC;              // 5152

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   ra;
    logic [N-1:0] rd;
    logic         tx;
    logic         busy;
    logic         done;

    logic [31:0] bank     [32];
    logic [31:0] exp_bank [32];

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         done_cyc  [$];
    logic [7:0] rx_bytes  [$];
    int         frame_err = 0;
    int         ra_bad    = 0;
    logic [4:0] prev_ra   = 5'd0;
    int         acc;

    always #5 clk = ~clk;

    assign rd = bank[ra];

    reg_dump_tx #(
        .N            (N),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ra    (ra),
        .rd    (rd),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (ra !== prev_ra && !(ra == prev_ra + 5'd1 || ra == 5'd0)) ra_bad++;
        prev_ra = ra;
    end

    // Host UART receiver: samples mid-bit on falling clock edges.
    initial begin
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (2) @(negedge clk);
                if (tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_bytes.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < DUMP_CYC + 200) begin
            tick(1);
            k++;
        end
        check(tag, 64'(done_cnt >= target), 64'd1);
    endtask

    // Accept edge is the next rising edge after start is raised.
    task automatic start_dump(output int accept);
        start  = 1'b1;
        accept = cyc + 1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic check_dump(input int base, input string tag);
        int bad;
        logic [31:0] w;
        bad = 0;
        if (rx_bytes.size() < base + 128) begin
            bad = 999;
        end else begin
            for (int j = 0; j < 128; j++) begin
                w = exp_bank[j / 4];
                if (rx_bytes[base + j] !== w[(3 - (j % 4)) * 8 +: 8]) bad++;
            end
        end
        check(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h11223300 + i;

        // Asynchronous reset between clock edges
        #3 rst = 1'b1;
        #1;
        check("rst_tx",   64'(tx),   64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ra",   64'(ra),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(100);
        check("idle_tx",    64'(tx),              64'd1);
        check("idle_busy",  64'(busy),            64'd0);
        check("idle_done",  64'(done_cnt),        64'd0);
        check("idle_ra",    64'(ra),              64'd0);
        check("idle_bytes", 64'(rx_bytes.size()), 64'd0);

        // Single full dump
        for (int i = 0; i < 32; i++) exp_bank[i] = bank[i];
        start_dump(acc);
        check("load_tx",   64'(tx),   64'd1);
        check("load_busy", 64'(busy), 64'd1);
        check("load_ra",   64'(ra),   64'd0);
        tick(1);
        check("start_bit_tx", 64'(tx), 64'd0);
        wait_done(1, "dump1_done_seen");
        // done is high in the cycle ending at edge acc + 32*161 + 1
        check("dump1_done_time", 64'(done_cyc[0] - acc), 64'(DUMP_CYC));
        tick(5);
        check("dump1_done_cnt", 64'(done_cnt),        64'd1);
        check("dump1_busy_end", 64'(busy),            64'd0);
        check("dump1_ra_held",  64'(ra),              64'd31);
        check("dump1_nbytes",   64'(rx_bytes.size()), 64'd128);
        check_dump(0, "dump1_bytes");
        check("dump1_first",  64'(rx_bytes[0]),   64'h11);
        check("dump1_byte3",  64'(rx_bytes[3]),   64'h00);
        check("dump1_byte4",  64'(rx_bytes[4]),   64'h11);
        check("dump1_last",   64'(rx_bytes[127]), 64'h1F);

        // Snapshot: write reg5 and reg6 while byte 1 of reg5 is on the wire
        rx_bytes.delete();
        for (int i = 0; i < 32; i++) exp_bank[i] = bank[i];
        exp_bank[6] = 32'hDEADBEEF;
        start_dump(acc);
        wait_cyc(acc + 5 * REG_CYC + 60);
        check("snap_ra", 64'(ra), 64'd5);
        bank[5] = 32'hDEADBEEF;
        bank[6] = 32'hDEADBEEF;
        wait_done(2, "snap_done_seen");
        tick(5);
        check("snap_nbytes", 64'(rx_bytes.size()), 64'd128);
        check_dump(0, "snap_bytes");
        check("snap_r5_b0", 64'(rx_bytes[20]), 64'h11);
        check("snap_r5_b3", 64'(rx_bytes[23]), 64'h05);
        check("snap_r6_b0", 64'(rx_bytes[24]), 64'hDE);
        check("snap_r6_b3", 64'(rx_bytes[27]), 64'hEF);
        bank[5] = 32'h11223305;
        bank[6] = 32'h11223306;

        // start pulses while busy are ignored
        rx_bytes.delete();
        for (int i = 0; i < 32; i++) exp_bank[i] = bank[i];
        ra_bad = 0;
        start_dump(acc);
        wait_cyc(acc + 50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_cyc(acc + 3000);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(3, "busy_done_seen");
        tick(200);
        check("busy_done_cnt", 64'(done_cnt),        64'd3);
        check("busy_nbytes",   64'(rx_bytes.size()), 64'd128);
        check("busy_idle",     64'(busy),            64'd0);
        check("busy_ra_mono",  64'(ra_bad),          64'd0);
        check_dump(0, "busy_bytes");

        // Reset during DATA of reg 3, byte 2
        start_dump(acc);
        wait_cyc(acc + 3 * REG_CYC + 1 + 80 + 10);
        check("mid_ra", 64'(ra), 64'd3);
        check("mid_in_data", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx",   64'(tx),   64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_ra",   64'(ra),   64'd0);
        #1 rst = 1'b0;
        tick(60);
        check("mid_no_done", 64'(done_cnt), 64'd3);
        rx_bytes.delete();
        start_dump(acc);
        wait_done(4, "redump_done_seen");
        tick(5);
        check("redump_time",   64'(done_cyc[3] - acc), 64'(DUMP_CYC));
        check("redump_nbytes", 64'(rx_bytes.size()),    64'd128);
        check_dump(0, "redump_bytes");

        // start held high across two dumps
        rx_bytes.delete();
        start = 1'b1;
        acc   = cyc + 1;
        wait_done(5, "cont_done1_seen");
        wait_done(6, "cont_done2_seen");
        start = 1'b0;
        check("cont_first_time", 64'(done_cyc[4] - acc),         64'(DUMP_CYC));
        check("cont_spacing",    64'(done_cyc[5] - done_cyc[4]), 64'(DUMP_CYC + 2));
        tick(200);
        check("cont_done_cnt", 64'(done_cnt),        64'd6);
        check("cont_idle",     64'(busy),            64'd0);
        check("cont_nbytes",   64'(rx_bytes.size()), 64'd256);
        check_dump(0,   "cont_bytes_a");
        check_dump(128, "cont_bytes_b");
        check("framing", 64'(frame_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
